// File: rtl/display_source_sequencer_pkg.sv
// display_source_sequencer_pkg: source encodings, FSM states and index stepping
package display_source_sequencer_pkg;
  localparam int NUM_SOURCES    = 11;
  localparam int SOURCE_INDEX_W = 4;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R0   = 4'd0;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R1   = 4'd1;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R2   = 4'd2;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R3   = 4'd3;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R4   = 4'd4;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R5   = 4'd5;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R6   = 4'd6;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_R7   = 4'd7;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_PC   = 4'd8;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_DATA = 4'd9;
  localparam logic [SOURCE_INDEX_W-1:0] SRC_ADDR = 4'd10;
  typedef enum logic {S_MANUAL, S_AUTO} state_t;
  function automatic logic [SOURCE_INDEX_W-1:0] next_index(input logic [SOURCE_INDEX_W-1:0] idx);
    return (idx == SOURCE_INDEX_W'(NUM_SOURCES - 1)) ? SRC_R0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw active-low button, debounces it and emits one-cycle press events
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_button_n,
  output logic o_press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_flip;
  assign w_diff  = r_sync[1] != r_level;
  assign w_flip  = w_diff && (r_cnt == CNT_MAX);
  // The event fires in the cycle the accepted level is about to fall, so consumers act on the same edge
  assign o_press = w_flip & r_level;
  // Synchronize the raw level and accept it only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_button_n};
      r_level <= w_flip ? ~r_level : r_level;
      r_cnt   <= (!w_diff || w_flip) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/display_source_sequencer.sv
// display_source_sequencer: picks which debug value drives the data HEX group, stepped manually or rotated on a timer
module display_source_sequencer
  import display_source_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      step_button_n,
  input  logic                      mode_button_n,
  input  logic [15:0]               r0,
  input  logic [15:0]               r1,
  input  logic [15:0]               r2,
  input  logic [15:0]               r3,
  input  logic [15:0]               r4,
  input  logic [15:0]               r5,
  input  logic [15:0]               r6,
  input  logic [15:0]               r7,
  input  logic [15:0]               program_count,
  input  logic [15:0]               data_bus,
  input  logic [15:0]               address_bus,
  output logic [15:0]               display_value,
  output logic [SOURCE_INDEX_W-1:0] source_index,
  output logic                      auto_mode
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL_CYCLES - 1);
  state_t                    r_state;
  state_t                    w_state_n;
  logic [SOURCE_INDEX_W-1:0] r_idx;
  logic [SOURCE_INDEX_W-1:0] w_idx_n;
  logic [DW_W-1:0]           r_dwell;
  logic [DW_W-1:0]           w_dwell_n;
  logic [15:0]               r_disp;
  logic [15:0]               w_src;
  logic                      w_step;
  logic                      w_mode;
  logic                      w_expire;
  logic                      w_adv;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clock(clock), .reset(reset), .i_button_n(step_button_n), .o_press(w_step)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clock(clock), .reset(reset), .i_button_n(mode_button_n), .o_press(w_mode)
  );
  // Mode toggles on a mode event; a step event and dwell expiry merge into a single advance
  always_comb begin
    w_expire  = (r_state == S_AUTO) && (r_dwell == DWELL_MAX);
    w_adv     = w_step | w_expire;
    w_state_n = w_mode ? ((r_state == S_AUTO) ? S_MANUAL : S_AUTO) : r_state;
    w_idx_n   = w_adv ? next_index(r_idx) : r_idx;
    w_dwell_n = ((r_state == S_MANUAL) || w_adv || w_mode) ? '0 : r_dwell + 1'b1;
  end
  // Select the live source for the current index
  always_comb begin
    w_src = 16'h0000;
    case (r_idx)
      SRC_R0:   w_src = r0;
      SRC_R1:   w_src = r1;
      SRC_R2:   w_src = r2;
      SRC_R3:   w_src = r3;
      SRC_R4:   w_src = r4;
      SRC_R5:   w_src = r5;
      SRC_R6:   w_src = r6;
      SRC_R7:   w_src = r7;
      SRC_PC:   w_src = program_count;
      SRC_DATA: w_src = data_bus;
      SRC_ADDR: w_src = address_bus;
      default:  w_src = 16'h0000;
    endcase
  end
  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_MANUAL;
    else       r_state <= w_state_n;
  end
  // Index, dwell timer and registered display value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx   <= SRC_R0;
      r_dwell <= '0;
      r_disp  <= 16'h0000;
    end else begin
      r_idx   <= w_idx_n;
      r_dwell <= w_dwell_n;
      r_disp  <= w_src;
    end
  end
  assign display_value = r_disp;
  assign source_index  = r_idx;
  assign auto_mode     = (r_state == S_AUTO);
endmodule

// File: tb/tb_display_source_sequencer.sv
// tb_display_source_sequencer: directed vectors for debounce, wrap, auto rotation, event merging and reset
module tb_display_source_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step_button_n = 1'b1;
  logic        mode_button_n = 1'b1;
  logic [15:0] r0 = 16'h0000, r1 = 16'h1010, r2 = 16'h2020, r3 = 16'h3030;
  logic [15:0] r4 = 16'h4040, r5 = 16'h5050, r6 = 16'h6060, r7 = 16'h7070;
  logic [15:0] program_count = 16'hABCD, data_bus = 16'h1234, address_bus = 16'h5678;
  logic [15:0] display_value;
  logic [3:0]  source_index;
  logic        auto_mode;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  idx;
    logic [15:0] disp;
  } vec_t;
  vec_t tbl[11];

  display_source_sequencer #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .step_button_n(step_button_n), .mode_button_n(mode_button_n),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .program_count(program_count), .data_bus(data_bus), .address_bus(address_bus),
    .display_value(display_value), .source_index(source_index), .auto_mode(auto_mode)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic press_step();
    step_button_n = 1'b0;
    tick(6);
    step_button_n = 1'b1;
    tick(6);
  endtask

  initial begin
    tbl[0]  = '{4'd1,  16'h1010};
    tbl[1]  = '{4'd2,  16'h2020};
    tbl[2]  = '{4'd3,  16'h3030};
    tbl[3]  = '{4'd4,  16'h4040};
    tbl[4]  = '{4'd5,  16'h5050};
    tbl[5]  = '{4'd6,  16'h6060};
    tbl[6]  = '{4'd7,  16'h7070};
    tbl[7]  = '{4'd8,  16'hABCD};
    tbl[8]  = '{4'd9,  16'h1234};
    tbl[9]  = '{4'd10, 16'h5678};
    tbl[10] = '{4'd0,  16'h0000};
    tick(2);
    reset = 1'b0;
    check("rst_idx", 16'(source_index), 16'd0);
    check("rst_auto", 16'(auto_mode), 16'd0);
    check("rst_disp", display_value, 16'h0000);
    tick(1);
    check("post_rst_disp", display_value, 16'h0000);
    // short glitch is rejected
    step_button_n = 1'b0;
    tick(3);
    step_button_n = 1'b1;
    tick(10);
    check("glitch_idx", 16'(source_index), 16'd0);
    // held press is accepted exactly once
    step_button_n = 1'b0;
    tick(5);
    check("hold_not_yet", 16'(source_index), 16'd0);
    tick(1);
    check("hold_idx", 16'(source_index), 16'd1);
    check("hold_disp_lag", display_value, 16'h0000);
    tick(1);
    check("hold_disp", display_value, 16'h1010);
    tick(3);
    check("hold_once", 16'(source_index), 16'd1);
    step_button_n = 1'b1;
    tick(8);
    check("release_idx", 16'(source_index), 16'd1);
    // asynchronous reset mid-clock clears immediately
    #3 reset = 1'b1;
    #1;
    check("async_idx", 16'(source_index), 16'd0);
    check("async_auto", 16'(auto_mode), 16'd0);
    check("async_disp", display_value, 16'h0000);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(1);
    check("async_post_disp", display_value, 16'h0000);
    // wrap through all sources
    for (int i = 0; i < 11; i++) begin
      press_step();
      check($sformatf("wrap%0d_idx", i), 16'(source_index), 16'(tbl[i].idx));
      check($sformatf("wrap%0d_disp", i), display_value, tbl[i].disp);
    end
    // enter auto mode and rotate every 8 cycles
    mode_button_n = 1'b0;
    tick(6);
    check("auto_on", 16'(auto_mode), 16'd1);
    check("auto_idx0", 16'(source_index), 16'd0);
    mode_button_n = 1'b1;
    tick(7);
    check("auto_before1", 16'(source_index), 16'd0);
    tick(1);
    check("auto_adv1", 16'(source_index), 16'd1);
    tick(7);
    check("auto_before2", 16'(source_index), 16'd1);
    // step press lands 5 cycles after the next auto advance
    step_button_n = 1'b0;
    tick(1);
    check("auto_adv2", 16'(source_index), 16'd2);
    tick(5);
    check("auto_step_single", 16'(source_index), 16'd3);
    step_button_n = 1'b1;
    tick(7);
    check("auto_restart_before", 16'(source_index), 16'd3);
    tick(1);
    check("auto_restart_adv", 16'(source_index), 16'd4);
    // simultaneous step and mode events
    step_button_n = 1'b0;
    mode_button_n = 1'b0;
    tick(5);
    check("both_before", 16'(source_index), 16'd4);
    tick(1);
    check("both_idx", 16'(source_index), 16'd5);
    check("both_mode", 16'(auto_mode), 16'd0);
    step_button_n = 1'b1;
    mode_button_n = 1'b1;
    tick(6);
    tick(50);
    check("frozen_idx", 16'(source_index), 16'd5);
    check("frozen_mode", 16'(auto_mode), 16'd0);
    // live source tracking at the PC index
    repeat (3) press_step();
    check("pc_idx", 16'(source_index), 16'd8);
    check("pc_disp", display_value, 16'hABCD);
    program_count = 16'h0042;
    tick(1);
    check("pc_live", display_value, 16'h0042);
    // reset in the middle of a dwell period
    mode_button_n = 1'b0;
    tick(6);
    check("auto2_on", 16'(auto_mode), 16'd1);
    mode_button_n = 1'b1;
    tick(6);
    check("auto2_idx", 16'(source_index), 16'd8);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_idx", 16'(source_index), 16'd0);
    check("mid_rst_auto", 16'(auto_mode), 16'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(20);
    check("mid_rst_hold_idx", 16'(source_index), 16'd0);
    check("mid_rst_hold_auto", 16'(auto_mode), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
